// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    // One buffered fetch result: the address it came from and the word returned.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; storage for buffered fetch entries.
// Reads are combinational from the head slot and return zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale slots are never visible because reads are masked when empty.
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between instruction memory and decode.
// Issues sequential fetches, reserves buffer space at issue time so every
// response has a slot, and discards responses that belong to a redirected stream.
module fetch_queue #(
    parameter int               XLEN            = fetch_queue_pkg::XLEN,
    parameter int               DEPTH           = 4,
    parameter int               MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = fetch_queue_pkg::FETCH_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [XLEN-1:0]          dec_pc,
    output logic [31:0]              dec_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    import fetch_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_q, drop_d;

    logic             fifo_flush;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     rsp_entry;
    fetch_entry_t     head_entry;

    logic [SUM_W-1:0] reserved;
    logic [XLEN-1:0]  redirect_target;
    logic             req_fire;
    logic             rsp_ok;

    // Slots already spoken for: buffered entries plus requests whose data will be kept.
    assign reserved = SUM_W'(fifo_count) + SUM_W'(outstanding_q) - SUM_W'(drop_q);

    assign imem_req_valid = rst_n && !redirect_valid
                          && (reserved < SUM_W'(DEPTH))
                          && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is stray and must not disturb the counters.
    assign rsp_ok = imem_rsp_valid && (outstanding_q != '0);

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    assign rsp_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign dec_valid = !fifo_empty && !redirect_valid;
    assign dec_pc    = head_entry.pc;
    assign dec_instr = head_entry.instr;
    assign fifo_pop  = dec_valid && dec_ready;
    assign occupancy = fifo_count;

    // Next-state for fetch/response pointers and the outstanding/drop counters; redirect wins.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        fifo_flush    = 1'b0;
        fifo_push     = 1'b0;

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fifo_flush    = 1'b1;
            fetch_pc_d    = redirect_target;
            rsp_pc_d      = redirect_target;
            outstanding_d = outstanding_q - OUT_W'(rsp_ok);
            drop_d        = outstanding_q - OUT_W'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);

            case ({req_fire, rsp_ok})
                2'b10:   outstanding_d = outstanding_q + 1'b1;
                2'b01:   outstanding_d = outstanding_q - 1'b1;
                default: outstanding_d = outstanding_q;
            endcase

            if (rsp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + XLEN'(4);
                end
            end
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_entries (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (rsp_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Memory must never answer a request that was not made.
    a_rsp_has_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (outstanding_q != '0));

    // Issue-time reservation guarantees a kept response always finds a free slot.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a 1-cycle in-order memory model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [2:0]  occupancy;

    logic        mem_hold;
    logic [31:0] pend_q[$];
    logic [31:0] fire_log[$];
    int          checks = 0;
    int          errors = 0;
    int          idx;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN            (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .occupancy      (occupancy)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    function automatic logic [31:0] fire_at(input int i);
        return (i < fire_log.size()) ? fire_log[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_dec_valid();
        for (int i = 0; i < 20 && dec_valid !== 1'b1; i++) tick();
    endtask

    // Memory model: returns each accepted request one cycle later, in order, unless held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
            if (!mem_hold && pend_q.size() != 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= instr_of(pend_q.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Log of every fired request address.
    always @(posedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) fire_log.push_back(imem_req_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        mem_hold       = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_req_addr",  imem_req_addr, 32'h0);
        check("rst_dec_pc",    dec_pc, 0);
        check("rst_dec_instr", dec_instr, 0);

        rst_n = 1'b1;
        #1;
        check("rel_req_valid", imem_req_valid, 1);
        check("rel_req_addr",  imem_req_addr, 32'h0);
        check("rel_dec_valid", dec_valid, 0);
        tick();
        check("c1_dec_valid", dec_valid, 0);
        check("c1_req_addr",  imem_req_addr, 32'h4);

        // Streaming: one pair per cycle
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_valid", dec_valid, 1);
            check("stream_pc",    dec_pc, 32'(4 * i));
            check("stream_instr", dec_instr, instr_of(32'(4 * i)));
        end
        check("fire0", fire_at(0), 32'h0);
        check("fire1", fire_at(1), 32'h4);

        // Backpressure: fill to DEPTH and stop fetching
        dec_ready = 1'b0;
        repeat (5) tick();
        check("bp_occupancy", occupancy, 4);
        check("bp_dec_pc",    dec_pc, 32'hC);
        check("bp_req_valid", imem_req_valid, 0);
        check("bp_req_addr",  imem_req_addr, 32'h1C);
        check("bp_fires",     fire_log.size(), 7);

        // Drain in order, fetching resumes
        dec_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("drain_valid", dec_valid, 1);
            check("drain_pc",    dec_pc, 32'hC + 32'(4 * i));
        end
        check("drain_instr", dec_instr, instr_of(32'h20));
        check("resume_fire", fire_at(7), 32'h1C);

        // Quiesce: stop requests, let everything drain
        imem_req_ready = 1'b0;
        repeat (6) tick();
        check("idle_occupancy", occupancy, 0);
        check("idle_req_addr",  imem_req_addr, 32'h2C);

        // Redirect with two requests outstanding
        mem_hold       = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        tick();
        check("maxout_req_valid", imem_req_valid, 0);
        check("maxout_last_fire", fire_log[$], 32'h30);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        check("rdA_req_valid", imem_req_valid, 0);
        idx = fire_log.size();
        tick();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        #1;
        check("rdA_req_addr",  imem_req_addr, 32'h100);
        check("rdA_occupancy", occupancy, 0);
        wait_dec_valid();
        check("rdA_dec_valid", dec_valid, 1);
        check("rdA_dec_pc",    dec_pc, 32'h100);
        check("rdA_dec_instr", dec_instr, instr_of(32'h100));
        check("rdA_fire",      fire_at(idx), 32'h100);
        tick();
        check("rdA_next_pc",   dec_pc, 32'h104);

        // Redirect with a response in the same cycle and three entries buffered
        dec_ready = 1'b0;
        tick();
        tick();
        check("rdB_pre_occ", occupancy, 3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        check("rdB_dec_valid_gated", dec_valid, 0);
        check("rdB_req_valid_gated", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rdB_occupancy", occupancy, 0);
        check("rdB_req_valid", imem_req_valid, 1);
        check("rdB_req_addr",  imem_req_addr, 32'h200);
        dec_ready = 1'b1;
        wait_dec_valid();
        check("rdB_dec_pc",    dec_pc, 32'h200);
        check("rdB_dec_instr", dec_instr, instr_of(32'h200));

        // Reset mid-stream with three entries buffered
        dec_ready = 1'b0;
        tick();
        tick();
        check("mrst_pre_occ", occupancy, 3);
        rst_n = 1'b0;
        #1;
        check("mrst_dec_valid", dec_valid, 0);
        check("mrst_occupancy", occupancy, 0);
        check("mrst_req_valid", imem_req_valid, 0);
        check("mrst_req_addr",  imem_req_addr, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        #1;
        check("mrst_restart_addr", imem_req_addr, 32'h0);
        wait_dec_valid();
        check("mrst_dec_pc",    dec_pc, 32'h0);
        check("mrst_dec_instr", dec_instr, instr_of(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
